// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control sequencer: state codes, opcodes,
// datapath select/function encodings, flag indices and a one-hot helper.
package control_pkg;

  // FSM state codes (plain constants so the debug State port stays a raw vector)
  typedef logic [2:0] state_t;
  localparam state_t StInit   = 3'd0;
  localparam state_t StFetchL = 3'd1;
  localparam state_t StFetchH = 3'd2;
  localparam state_t StExec1  = 3'd3;
  localparam state_t StExec2  = 3'd4;
  localparam state_t StHalt   = 3'd5;

  // Opcodes (IROut[15:10]); 0x10-0x1F is the ALU group
  localparam logic [5:0] OpBra = 6'h00;
  localparam logic [5:0] OpBne = 6'h01;
  localparam logic [5:0] OpBeq = 6'h02;
  localparam logic [5:0] OpLdi = 6'h20;
  localparam logic [5:0] OpLd  = 6'h21;
  localparam logic [5:0] OpSt  = 6'h22;
  localparam logic [5:0] OpHlt = 6'h3F;
  localparam logic [1:0] OpAluHi = 2'b01;

  typedef enum logic [3:0] {
    ClsNop, ClsBra, ClsBne, ClsBeq, ClsAlu, ClsLdi, ClsLd, ClsSt, ClsHlt
  } op_class_e;

  // Address register file
  localparam logic [1:0] ArfOutPc    = 2'b00;
  localparam logic [1:0] ArfOutAr    = 2'b10;
  localparam logic [2:0] ArfRegPc    = 3'b100;
  localparam logic [2:0] ArfRegAll   = 3'b111;
  localparam logic [1:0] ArfFunInc   = 2'b01;
  localparam logic [1:0] ArfFunLoad  = 2'b10;
  localparam logic [1:0] ArfFunClear = 2'b11;

  // Register file
  localparam logic [2:0] RfFunLoad  = 3'b010;
  localparam logic [2:0] RfFunClear = 3'b011;
  localparam logic [3:0] RfRegAll   = 4'b1111;

  // DR, ALU and muxes
  localparam logic [1:0] DrFunLoadByte = 2'b01;
  localparam logic [4:0] AluPassA      = 5'b10000;
  localparam logic [1:0] MuxAAlu       = 2'b00;
  localparam logic [1:0] MuxADr        = 2'b10;
  localparam logic [1:0] MuxAImm       = 2'b11;
  localparam logic [1:0] MuxBImm       = 2'b11;

  // ALU_FlagsOut bit positions {Z,C,N,O}
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagO = 0;

  // Register index 0..3 selects R1..R4, with R1 in the MSB
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the ALU datapath system.
interface control_sequencer_if;
  import control_pkg::*;

  logic [15:0] ir_out;
  logic [3:0]  alu_flags_out;

  logic [2:0]  rf_out_a_sel;
  logic [2:0]  rf_out_b_sel;
  logic [2:0]  rf_fun_sel;
  logic [3:0]  rf_reg_sel;
  logic [3:0]  rf_scr_sel;
  logic [4:0]  alu_fun_sel;
  logic        alu_wf;
  logic [1:0]  arf_out_c_sel;
  logic [1:0]  arf_out_d_sel;
  logic [1:0]  arf_fun_sel;
  logic [2:0]  arf_reg_sel;
  logic        ir_lh;
  logic        ir_write;
  logic        mem_wr;
  logic        mem_cs;
  logic        dr_e;
  logic        mux_d_sel;
  logic [1:0]  dr_fun_sel;
  logic [1:0]  mux_a_sel;
  logic [1:0]  mux_b_sel;
  logic [1:0]  mux_c_sel;

  // Sequencer side
  modport master (
    input  ir_out, alu_flags_out,
    output rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
    output alu_fun_sel, alu_wf,
    output arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
    output ir_lh, ir_write, mem_wr, mem_cs, dr_e, mux_d_sel,
    output dr_fun_sel, mux_a_sel, mux_b_sel, mux_c_sel
  );

  // Datapath side
  modport slave (
    output ir_out, alu_flags_out,
    input  rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
    input  alu_fun_sel, alu_wf,
    input  arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
    input  ir_lh, ir_write, mem_wr, mem_cs, dr_e, mux_d_sel,
    input  dr_fun_sel, mux_a_sel, mux_b_sel, mux_c_sel
  );

endinterface

// File: rtl/instr_decoder.sv
// Pure combinational instruction decode: opcode class, register fields and
// whether the instruction needs a second execute cycle.
module instr_decoder
  import control_pkg::*;
(
  input  logic [15:0] ir_i,
  output op_class_e   op_class_o,
  output logic [1:0]  d_idx_o,
  output logic [2:0]  a_sel_o,
  output logic [2:0]  b_sel_o,
  output logic [1:0]  rx_o,
  output logic        s_o,
  output logic [3:0]  alu_op_o,
  output logic        two_cycle_o
);

  logic [5:0] op;

  assign op       = ir_i[15:10];
  assign s_o      = ir_i[9];
  assign rx_o     = ir_i[9:8];
  assign d_idx_o  = ir_i[7:6];
  assign a_sel_o  = ir_i[5:3];
  assign b_sel_o  = ir_i[2:0];
  assign alu_op_o = op[3:0];

  // Classify the opcode; anything unrecognised executes as a NOP
  always_comb begin
    op_class_o = ClsNop;
    if (op[5:4] == OpAluHi) begin
      op_class_o = ClsAlu;
    end else begin
      case (op)
        OpBra:   op_class_o = ClsBra;
        OpBne:   op_class_o = ClsBne;
        OpBeq:   op_class_o = ClsBeq;
        OpLdi:   op_class_o = ClsLdi;
        OpLd:    op_class_o = ClsLd;
        OpSt:    op_class_o = ClsSt;
        OpHlt:   op_class_o = ClsHlt;
        default: op_class_o = ClsNop;
      endcase
    end
  end

  assign two_cycle_o = (op_class_o == ClsLd);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: clears the machine, fetches a 16-bit instruction as
// two bytes, then drives one or two execute cycles from the decoded IR.
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  control_sequencer_if.master bus,
  output logic [2:0]          state_o,
  output logic                halted_o
);

  localparam logic [1:0] InitLast = 2'(INIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] init_cnt_q, init_cnt_d;

  op_class_e  op_class;
  logic [1:0] d_idx;
  logic [2:0] a_sel;
  logic [2:0] b_sel;
  logic [1:0] rx;
  logic       s_bit;
  logic [3:0] alu_op;
  logic       two_cycle;
  logic       flag_z;
  logic       take_branch;

  instr_decoder u_decoder (
    .ir_i        (bus.ir_out),
    .op_class_o  (op_class),
    .d_idx_o     (d_idx),
    .a_sel_o     (a_sel),
    .b_sel_o     (b_sel),
    .rx_o        (rx),
    .s_o         (s_bit),
    .alu_op_o    (alu_op),
    .two_cycle_o (two_cycle)
  );

  assign flag_z = bus.alu_flags_out[FlagZ];

  // Only Z steers branches; the remaining flags are consumed elsewhere
  logic unused_flags;
  assign unused_flags = ^bus.alu_flags_out[2:0];

  // Branch decision is taken combinationally from the live flags in EXEC1
  always_comb begin
    take_branch = 1'b0;
    case (op_class)
      ClsBra:  take_branch = 1'b1;
      ClsBne:  take_branch = ~flag_z;
      ClsBeq:  take_branch = flag_z;
      default: take_branch = 1'b0;
    endcase
  end

  // State register with synchronous reset that overrides any state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      StInit: begin
        if (init_cnt_q == InitLast) begin
          state_d    = StFetchL;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      StFetchL: state_d = StFetchH;
      StFetchH: state_d = StExec1;
      StExec1: begin
        if (op_class == ClsHlt) begin
          state_d = StHalt;
        end else if (two_cycle) begin
          state_d = StExec2;
        end else begin
          state_d = StFetchL;
        end
      end
      StExec2: state_d = StFetchL;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;
    endcase
  end

  // Control outputs: idle defaults, overridden per state and instruction
  always_comb begin
    bus.rf_out_a_sel  = '0;
    bus.rf_out_b_sel  = '0;
    bus.rf_fun_sel    = '0;
    bus.rf_reg_sel    = '0;
    bus.rf_scr_sel    = '0;
    bus.alu_fun_sel   = '0;
    bus.alu_wf        = 1'b0;
    bus.arf_out_c_sel = '0;
    bus.arf_out_d_sel = '0;
    bus.arf_fun_sel   = '0;
    bus.arf_reg_sel   = '0;
    bus.ir_lh         = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_cs        = 1'b1;
    bus.dr_e          = 1'b0;
    bus.mux_d_sel     = 1'b0;
    bus.dr_fun_sel    = '0;
    bus.mux_a_sel     = '0;
    bus.mux_b_sel     = '0;
    bus.mux_c_sel     = '0;

    case (state_q)
      StInit: begin
        bus.arf_reg_sel = ArfRegAll;
        bus.arf_fun_sel = ArfFunClear;
        bus.rf_reg_sel  = RfRegAll;
        bus.rf_fun_sel  = RfFunClear;
      end
      StFetchL, StFetchH: begin
        bus.arf_out_d_sel = ArfOutPc;
        bus.mem_cs        = 1'b0;
        bus.ir_write      = 1'b1;
        bus.ir_lh         = (state_q == StFetchH);
        bus.arf_reg_sel   = ArfRegPc;
        bus.arf_fun_sel   = ArfFunInc;
      end
      StExec1: begin
        case (op_class)
          ClsBra, ClsBne, ClsBeq: begin
            if (take_branch) begin
              bus.mux_b_sel   = MuxBImm;
              bus.arf_reg_sel = ArfRegPc;
              bus.arf_fun_sel = ArfFunLoad;
            end
          end
          ClsAlu: begin
            bus.rf_out_a_sel = a_sel;
            bus.rf_out_b_sel = b_sel;
            bus.mux_d_sel    = 1'b0;
            bus.alu_fun_sel  = {1'b1, alu_op};
            bus.alu_wf       = s_bit;
            bus.mux_a_sel    = MuxAAlu;
            bus.rf_reg_sel   = onehot4(d_idx);
            bus.rf_fun_sel   = RfFunLoad;
          end
          ClsLdi: begin
            bus.mux_a_sel  = MuxAImm;
            bus.rf_reg_sel = onehot4(rx);
            bus.rf_fun_sel = RfFunLoad;
          end
          ClsLd: begin
            bus.arf_out_d_sel = ArfOutAr;
            bus.mem_cs        = 1'b0;
            bus.dr_e          = 1'b1;
            bus.dr_fun_sel    = DrFunLoadByte;
          end
          ClsSt: begin
            bus.rf_out_a_sel  = {1'b0, rx};
            bus.mux_d_sel     = 1'b0;
            bus.alu_fun_sel   = AluPassA;
            bus.mux_c_sel     = 2'b00;
            bus.arf_out_d_sel = ArfOutAr;
            bus.mem_cs        = 1'b0;
            bus.mem_wr        = 1'b1;
          end
          default: ;
        endcase
      end
      StExec2: begin
        // Only LD reaches EXEC2: write the byte latched in DR into rx
        bus.mux_a_sel  = MuxADr;
        bus.rf_reg_sel = onehot4(rx);
        bus.rf_fun_sel = RfFunLoad;
      end
      default: ;
    endcase
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus process queues the
// expected control vector for each cycle, a monitor compares on the falling edge.
module tb_control_sequencer;
  import control_pkg::*;

  typedef struct packed {
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic       dr_e;
    logic       mux_d_sel;
    logic [1:0] dr_fun_sel;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_c_sel;
    logic [2:0] state;
    logic       halted;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       halted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ctl_t  exp_q[$];
  string name_q[$];

  control_sequencer_if bus ();

  control_sequencer #(
    .INIT_CYCLES (1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus.master),
    .state_o  (state),
    .halted_o (halted)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t c;
    c.rf_out_a_sel  = bus.rf_out_a_sel;
    c.rf_out_b_sel  = bus.rf_out_b_sel;
    c.rf_fun_sel    = bus.rf_fun_sel;
    c.rf_reg_sel    = bus.rf_reg_sel;
    c.rf_scr_sel    = bus.rf_scr_sel;
    c.alu_fun_sel   = bus.alu_fun_sel;
    c.alu_wf        = bus.alu_wf;
    c.arf_out_c_sel = bus.arf_out_c_sel;
    c.arf_out_d_sel = bus.arf_out_d_sel;
    c.arf_fun_sel   = bus.arf_fun_sel;
    c.arf_reg_sel   = bus.arf_reg_sel;
    c.ir_lh         = bus.ir_lh;
    c.ir_write      = bus.ir_write;
    c.mem_wr        = bus.mem_wr;
    c.mem_cs        = bus.mem_cs;
    c.dr_e          = bus.dr_e;
    c.mux_d_sel     = bus.mux_d_sel;
    c.dr_fun_sel    = bus.dr_fun_sel;
    c.mux_a_sel     = bus.mux_a_sel;
    c.mux_b_sel     = bus.mux_b_sel;
    c.mux_c_sel     = bus.mux_c_sel;
    c.state         = state;
    c.halted        = halted;
    return c;
  endfunction

  // Expected-vector builders
  function automatic ctl_t f_idle(input logic [2:0] st);
    ctl_t c = '0;
    c.mem_cs = 1'b1;
    c.state  = st;
    return c;
  endfunction

  function automatic ctl_t f_init();
    ctl_t c = f_idle(StInit);
    c.arf_reg_sel = 3'b111;
    c.arf_fun_sel = 2'b11;
    c.rf_reg_sel  = 4'b1111;
    c.rf_fun_sel  = 3'b011;
    return c;
  endfunction

  function automatic ctl_t f_fetch(input logic hi);
    ctl_t c = f_idle(hi ? StFetchH : StFetchL);
    c.mem_cs      = 1'b0;
    c.ir_write    = 1'b1;
    c.ir_lh       = hi;
    c.arf_reg_sel = 3'b100;
    c.arf_fun_sel = 2'b01;
    return c;
  endfunction

  function automatic ctl_t f_branch();
    ctl_t c = f_idle(StExec1);
    c.mux_b_sel   = 2'b11;
    c.arf_reg_sel = 3'b100;
    c.arf_fun_sel = 2'b10;
    return c;
  endfunction

  // One clock of stimulus: inputs for this cycle plus its expected outputs;
  // rst_v takes effect at the next rising edge
  task automatic cyc(input logic [15:0] ir, input logic [3:0] fl, input logic rst_v,
                     input ctl_t e, input string nm);
    @(posedge clk);
    #1;
    bus.ir_out        = ir;
    bus.alu_flags_out = fl;
    rst               = rst_v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch2();
    cyc(16'h0000, 4'h0, 1'b0, f_fetch(1'b0), "fetch_l");
    cyc(16'h0000, 4'h0, 1'b0, f_fetch(1'b1), "fetch_h");
  endtask

  // Monitor: compare every queued expectation against the live outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      ctl_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h (state %0d req %0d, flags %b)",
                 nm, a, e, a.state, e.state, bus.alu_flags_out);
      end
    end
  end

  initial begin
    ctl_t       e;
    logic [3:0] all_flags;
    all_flags = '0;
    all_flags[FlagZ] = 1'b1;
    all_flags[FlagC] = 1'b1;
    all_flags[FlagN] = 1'b1;
    all_flags[FlagO] = 1'b1;

    rst = 1'b1;
    bus.ir_out = '0;
    bus.alu_flags_out = '0;
    repeat (3) @(posedge clk);

    cyc(16'h0000, 4'h0, 1'b0, f_init(), "reset_init");
    fetch2();

    // LDI R3,0x5A
    e = f_idle(StExec1);
    e.mux_a_sel = 2'b11; e.rf_reg_sel = 4'b0010; e.rf_fun_sel = 3'b010;
    cyc(16'h825A, 4'h0, 1'b0, e, "ldi_r3");
    fetch2();

    // ALU op 0x11, S=0, d=R2, a=010, b=011
    e = f_idle(StExec1);
    e.rf_out_a_sel = 3'b010; e.rf_out_b_sel = 3'b011; e.alu_fun_sel = 5'b10001;
    e.rf_reg_sel = 4'b0100; e.rf_fun_sel = 3'b010;
    cyc(16'h4453, 4'h0, 1'b0, e, "alu_11");
    fetch2();

    cyc(16'h0840, 4'b1000, 1'b0, f_branch(), "beq_taken");
    fetch2();
    cyc(16'h0840, 4'b0000, 1'b0, f_idle(StExec1), "beq_not_taken");
    fetch2();
    cyc(16'h0400, 4'b0000, 1'b0, f_branch(), "bne_taken");
    fetch2();
    cyc(16'h0400, all_flags, 1'b0, f_idle(StExec1), "bne_not_taken");
    fetch2();
    cyc(16'h0000, all_flags, 1'b0, f_branch(), "bra");
    fetch2();

    // ST R4
    e = f_idle(StExec1);
    e.rf_out_a_sel = 3'b011; e.alu_fun_sel = 5'b10000; e.arf_out_d_sel = 2'b10;
    e.mem_cs = 1'b0; e.mem_wr = 1'b1;
    cyc(16'h8B00, 4'h0, 1'b0, e, "st_r4");
    fetch2();

    cyc(16'h1400, 4'h0, 1'b0, f_idle(StExec1), "nop_05");
    fetch2();

    // ALU op 0x1A, S=1, d=R4, a=000, b=001
    e = f_idle(StExec1);
    e.rf_out_b_sel = 3'b001; e.alu_fun_sel = 5'b11010; e.alu_wf = 1'b1;
    e.rf_reg_sel = 4'b0001; e.rf_fun_sel = 3'b010;
    cyc(16'h6AC1, 4'h0, 1'b0, e, "alu_1a_s");
    fetch2();

    // LD R1
    e = f_idle(StExec1);
    e.arf_out_d_sel = 2'b10; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun_sel = 2'b01;
    cyc(16'h8400, 4'h0, 1'b0, e, "ld_exec1");
    e = f_idle(StExec2);
    e.mux_a_sel = 2'b10; e.rf_reg_sel = 4'b1000; e.rf_fun_sel = 3'b010;
    cyc(16'h8400, 4'h0, 1'b0, e, "ld_exec2");
    fetch2();

    // HLT, then ten halted cycles; reset requested during the last one
    cyc(16'hFC00, 4'h0, 1'b0, f_idle(StExec1), "hlt_exec1");
    for (int i = 0; i < 10; i++) begin
      e = f_idle(StHalt);
      e.halted = 1'b1;
      cyc(16'hFC00, 4'h0, (i == 9), e, "halted");
    end
    cyc(16'h0000, 4'h0, 1'b0, f_init(), "init_after_halt");
    fetch2();

    // Reset asserted in EXEC1 of LD
    e = f_idle(StExec1);
    e.arf_out_d_sel = 2'b10; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun_sel = 2'b01;
    cyc(16'h8400, 4'h0, 1'b1, e, "ld_exec1_rst");
    cyc(16'h8400, 4'h0, 1'b0, f_init(), "init_mid_exec");
    cyc(16'h0000, 4'h0, 1'b0, f_fetch(1'b0), "fetch_l_after_init");

    // Drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives every select, enable and function input of the ALU datapath system (register file, address register file, ALU, DR, IR, memory, muxes A–D). It sits directly upstream of that datapath.
- It fetches a 16-bit instruction as two bytes from memory at PC into IR.
- It decodes IROut and sequences one or two execute cycles.
- It uses ALU flags for conditional branches.

Parameters:
- INIT_CYCLES, 1, number of clear cycles issued after reset before the first fetch (1..3).

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- IROut  in  16  instruction register contents
- ALU_FlagsOut  in  4  {Z,C,N,O}
- RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each
- RF_RegSel, RF_ScrSel  out  4 each
- ALU_FunSel  out  5
- ALU_WF  out  1
- ARF_OutCSel, ARF_OutDSel, ARF_FunSel  out  2 each
- ARF_RegSel  out  3
- IR_LH, IR_Write, Mem_WR, Mem_CS, DR_E, MuxDSel  out  1 each
- DR_FunSel, MuxASel, MuxBSel, MuxCSel  out  2 each
- State  out  3  current FSM state (debug)
- Halted  out  1  high in HALT

Behaviour:
- Idle defaults, driven in every state unless overridden:
  - RF_RegSel=0, RF_ScrSel=0, ARF_RegSel=0 (no register writes)
  - IR_Write=0, DR_E=0, ALU_WF=0
  - Mem_CS=1 (memory deselected), Mem_WR=0
  - All selects 0
- Encodings:
  - ARF_OutDSel: PC=00, AR=10, SP=11
  - ARF_RegSel one-hot: PC=100, AR=010, SP=001
  - ARF_FunSel: 00 dec, 01 inc, 10 load, 11 clear
  - RF_FunSel: 010 load, 011 clear
  - RF_RegSel one-hot: R1=1000 … R4=0001
  - DR_FunSel: 01 load byte, zero-extended
  - ALU pass-A: 5'b10000
- States and transitions: INIT → FETCH_L → FETCH_H → EXEC1 → (EXEC2) → FETCH_L; HALT is absorbing.
- Reset (sampled at a rising edge):
  - State=INIT and init counter=0 on the next cycle, regardless of the current state, including mid-execute.
  - Outputs revert to the INIT values the same cycle State changes.
- INIT:
  - ARF_RegSel=111, ARF_FunSel=11; RF_RegSel=1111, RF_FunSel=011.
  - Stays in INIT for INIT_CYCLES cycles, then goes to FETCH_L.
- FETCH_L:
  - ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0.
  - ARF_RegSel=100, ARF_FunSel=01 (PC+1).
- FETCH_H: same as FETCH_L but IR_LH=1.
- Decode is valid from EXEC1 onward:
  - op=IROut[15:10]
  - reg fields: d=IROut[8:6], a=IROut[5:3], b=IROut[2:0]; the low 2 bits of each field index R1..R4
  - S=IROut[9]
  - imm=IROut[7:0]
  - rx=IROut[9:8]
- Instruction actions:
  - op 0x00 BRA: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=10. One exec cycle.
  - op 0x01 BNE: BRA action only if Z=0, else idle. One exec cycle.
  - op 0x02 BEQ: BRA action only if Z=1, else idle. One exec cycle.
  - op 0x10–0x1F ALU:
    - RF_OutASel=a, RF_OutBSel=b, MuxDSel=0
    - ALU_FunSel={1'b1, op[3:0]}, ALU_WF=S
    - MuxASel=00, RF_RegSel=onehot(d), RF_FunSel=010
    - One exec cycle.
  - op 0x20 LDI: MuxASel=11, RF_RegSel=onehot(rx), RF_FunSel=010. One cycle.
  - op 0x21 LD, two exec cycles:
    - EXEC1: ARF_OutDSel=10, Mem_CS=0, DR_E=1, DR_FunSel=01.
    - EXEC2: MuxASel=10, RF_RegSel=onehot(rx), RF_FunSel=010.
  - op 0x22 ST, one cycle:
    - RF_OutASel=rx, MuxDSel=0, ALU_FunSel=10000, MuxCSel=00.
    - ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
  - op 0x3F HLT: next state HALT. HALT holds idle defaults with Halted=1 until Reset.
  - Any other op: NOP (idle in EXEC1), then FETCH_L.
- Branch conditions sample ALU_FlagsOut during EXEC1 (combinational decision).
- Timing:
  - All outputs are a combinational function of registered state plus IROut/flags.
  - No write enable may be asserted in two consecutive states unless listed above.
  - Instruction latency: 3 cycles, or 4 for LD.
- PC increments exactly twice per instruction.

Decomposition:
- Package control_pkg holds:
  - state enum
  - opcode constants
  - ARF/RF/DR function and select encodings
  - flag bit indices (Z=3, C=2, N=1, O=0)
  - onehot4 function
- Sub-module instr_decoder (pure combinational): IROut → opcode class, fields, exec length.
- The FSM and output logic stay in control_sequencer.

Test Plan:
- Reset asserted mid-EXEC1 of LD → next cycle State=INIT, ARF_RegSel=111, ARF_FunSel=11, RF_RegSel=1111; FETCH_L after INIT_CYCLES.
- FETCH_L, FETCH_H → IR_Write=1 both cycles with IR_LH 0 then 1; ARF_RegSel=100 and ARF_FunSel=01 in both.
- IROut=0x825A (LDI R3,0x5A) in EXEC1 → MuxASel=11, RF_RegSel=0010, RF_FunSel=010; FETCH_L next.
- IROut=0x4453 (op 0x11, S=0, d=R2,a=R3,b=R4) → ALU_FunSel=10001, ALU_WF=0, RF_OutASel=010, RF_OutBSel=011, RF_RegSel=0100.
- BEQ (IROut=0x0840): with flags=1000 → ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11; with flags=0000 → all idle.
- LD R1 then HLT (0xFC00) → EXEC1 has DR_E=1 and Mem_CS=0, EXEC2 has MuxASel=10 and RF_RegSel=1000; after HLT, Halted=1 held for 10 cycles until Reset.
